// File: rtl/dac_setpoint_ramp.sv
// Setpoint slew limiter ahead of the DAC8563 serializer: accepts clamped target
// codes over valid/ready and walks DATA toward them by a bounded step per tick.
module dac_setpoint_ramp #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned UPDATE_HZ  = 10_000,
    parameter logic [15:0] CODE_MIN   = 16'h0000,
    parameter logic [15:0] CODE_MAX   = 16'hFFFF,
    parameter logic [15:0] RESET_CODE = 16'h8000
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        SET_VALID,
    output logic        SET_READY,
    input  logic [15:0] SET_CODE,
    input  logic [15:0] SET_STEP,
    input  logic        HOLD,
    output logic [15:0] DATA,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned CODE_W   = 16;
    localparam int unsigned TICK_DIV = CLK_FREQ / UPDATE_HZ;
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] data_q, data_d;
    logic [CODE_W-1:0] target_q, target_d;
    logic [CODE_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              tick_c;
    logic              accept_c;
    logic              up_c;
    logic              last_step_c;
    logic [CODE_W:0]   diff_c;
    logic [CODE_W-1:0] clamped_c;

    function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
        if (code < CODE_MIN) begin
            return CODE_MIN;
        end
        if (code > CODE_MAX) begin
            return CODE_MAX;
        end
        return code;
    endfunction

    // Tick strobe, handshake and ramp distance, all derived from registered state.
    always_comb begin
        tick_c      = (cnt_q == CNT_W'(TICK_DIV - 1));
        accept_c    = SET_VALID & ready_q;
        clamped_c   = clamp_code(SET_CODE);
        up_c        = (target_q > data_q);
        diff_c      = up_c ? ({1'b0, target_q} - {1'b0, data_q})
                           : ({1'b0, data_q} - {1'b0, target_q});
        last_step_c = (step_q == {CODE_W{1'b0}}) || (diff_c <= {1'b0, step_q});
    end

    // Next-state and datapath; a new target takes priority over a coincident tick.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        target_d = target_q;
        step_d   = step_q;
        done_d   = 1'b0;
        ready_d  = 1'b1;
        cnt_d    = tick_c ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));

        if (accept_c) begin
            target_d = clamped_c;
            step_d   = SET_STEP;
            if (clamped_c != data_q) begin
                state_d = RAMP;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if ((state_q == RAMP) && tick_c && !HOLD) begin
            if (last_step_c) begin
                data_d  = target_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (up_c) begin
                data_d = data_q + step_q;
            end else begin
                data_d = data_q - step_q;
            end
        end

        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            data_q   <= RESET_CODE;
            target_q <= RESET_CODE;
            step_q   <= {CODE_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            target_q <= target_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign DATA      = data_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SET_READY = ready_q;

endmodule

// File: tb/tb_dac_setpoint_ramp.sv
// Bench for dac_setpoint_ramp: directed sequences, a clamp/step table and
// randomized traffic checked cycle by cycle against an arithmetic reference model.
module tb_dac_setpoint_ramp;

    localparam int          TDIV  = 5;
    localparam logic [15:0] C_MIN = 16'h0100;
    localparam logic [15:0] C_MAX = 16'hF000;
    localparam logic [15:0] C_RST = 16'h8000;

    logic        SYS_CLK   = 1'b0;
    logic        RST       = 1'b1;
    logic        SET_VALID = 1'b0;
    logic [15:0] SET_CODE  = 16'h0000;
    logic [15:0] SET_STEP  = 16'h0000;
    logic        HOLD      = 1'b0;
    logic        SET_READY;
    logic [15:0] DATA;
    logic        BUSY;
    logic        DONE;

    dac_setpoint_ramp #(
        .CLK_FREQ  (TDIV),
        .UPDATE_HZ (1),
        .CODE_MIN  (C_MIN),
        .CODE_MAX  (C_MAX),
        .RESET_CODE(C_RST)
    ) dut (
        .SYS_CLK  (SYS_CLK),
        .RST      (RST),
        .SET_VALID(SET_VALID),
        .SET_READY(SET_READY),
        .SET_CODE (SET_CODE),
        .SET_STEP (SET_STEP),
        .HOLD     (HOLD),
        .DATA     (DATA),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: target/position arithmetic on integers, tick phase as a cycle count.
    logic [15:0] m_data   = C_RST;
    logic [15:0] m_target = C_RST;
    logic [15:0] m_step   = 16'h0000;
    logic        m_done   = 1'b0;
    logic        m_ready  = 1'b0;
    int          m_phase  = 0;

    function automatic logic [15:0] clamp_ref(input logic [15:0] c);
        if (c < C_MIN) return C_MIN;
        if (c > C_MAX) return C_MAX;
        return c;
    endfunction

    function automatic logic [15:0] move_toward(input logic [15:0] cur, input logic [15:0] tgt,
                                                input logic [15:0] st);
        int gap;
        int mag;
        gap = int'(tgt) - int'(cur);
        mag = (gap >= 0) ? gap : -gap;
        if (st == 16'h0000 || mag <= int'(st)) return tgt;
        if (gap > 0) return 16'(int'(cur) + int'(st));
        return 16'(int'(cur) - int'(st));
    endfunction

    always @(posedge SYS_CLK) begin
        if (RST) begin
            m_data   <= C_RST;
            m_target <= C_RST;
            m_step   <= 16'h0000;
            m_done   <= 1'b0;
            m_ready  <= 1'b0;
            m_phase  <= 0;
        end else begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_phase <= (m_phase + 1) % TDIV;
            if (SET_VALID && m_ready) begin
                m_target <= clamp_ref(SET_CODE);
                m_step   <= SET_STEP;
                if (clamp_ref(SET_CODE) == m_data) m_done <= 1'b1;
            end else if (m_phase == TDIV - 1 && !HOLD && m_data != m_target) begin
                m_data <= move_toward(m_data, m_target, m_step);
                if (move_toward(m_data, m_target, m_step) == m_target) m_done <= 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge SYS_CLK);
        #1;
        n_vec++;
        if ({DATA, BUSY, DONE, SET_READY} !== {m_data, (m_data != m_target), m_done, m_ready}) begin
            n_err++;
            $display("FAIL model @%0t: got DATA=%h BUSY=%b DONE=%b READY=%b, expected DATA=%h BUSY=%b DONE=%b READY=%b",
                     $time, DATA, BUSY, DONE, SET_READY, m_data, (m_data != m_target), m_done, m_ready);
        end
        n_vec++;
        if (DATA < C_MIN || DATA > C_MAX) begin
            n_err++;
            $display("FAIL window @%0t: got DATA=%h, expected within [%h,%h]", $time, DATA, C_MIN, C_MAX);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance until the current cycle is a tick cycle (bounded).
    task automatic wait_tick();
        for (int i = 0; i < TDIV + 1 && m_phase != TDIV - 1; i++) cyc();
        n_vec++;
        if (m_phase != TDIV - 1) begin
            n_err++;
            $display("FAIL wait_tick: got phase %0d, expected %0d", m_phase, TDIV - 1);
        end
    endtask

    task automatic accept(input logic [15:0] code, input logic [15:0] step);
        SET_VALID = 1'b1;
        SET_CODE  = code;
        SET_STEP  = step;
        cyc();
        SET_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) cyc();
        RST = 1'b0;
    endtask

    typedef struct {
        logic [15:0] code;
        logic [15:0] step;
        logic [15:0] exp_data;
        int          exp_chg;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [15:0] prev;
        int          nchg;
        int          ndone;

        tbl[0] = '{16'hEFF0, 16'h0000, 16'hEFF0, 1};
        tbl[1] = '{16'hFFFF, 16'h0100, 16'hF000, 1};
        tbl[2] = '{16'h0000, 16'h0000, 16'h0100, 1};
        tbl[3] = '{16'h0050, 16'h2000, 16'h0100, 0};
        tbl[4] = '{16'h7FFF, 16'h1234, 16'h7FFF, 7};
        tbl[5] = '{16'h7FFF, 16'h0001, 16'h7FFF, 0};
        tbl[6] = '{16'h0200, 16'h3000, 16'h0200, 3};
        tbl[7] = '{16'h0000, 16'hFFFF, 16'h0100, 1};

        // Reset values and delayed ready
        do_reset();
        chk("rst DATA", DATA, C_RST);
        chk("rst BUSY", BUSY, 0);
        chk("rst DONE", DONE, 0);
        chk("rst READY first cycle", SET_READY, 0);
        cyc();
        chk("READY after first cycle", SET_READY, 1);

        // Up-ramp in steps of 4
        accept(16'h8010, 16'h0004);
        chk("up accept DATA", DATA, 16'h8000);
        chk("up accept BUSY", BUSY, 1);
        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            cyc();
            chk("up DATA", DATA, 32'(16'h8000 + 4 * k));
            chk("up DONE", DONE, 32'(k == 4));
            chk("up BUSY", BUSY, 32'(k != 4));
        end
        cyc();
        chk("up DONE single", DONE, 0);
        chk("up BUSY after", BUSY, 0);

        // Retarget colliding with a tick
        do_reset();
        cyc();
        accept(16'h8010, 16'h0004);
        wait_tick(); cyc();
        wait_tick(); cyc();
        chk("retarget start DATA", DATA, 16'h8008);
        wait_tick();
        accept(16'h8000, 16'h0008);
        chk("collide DATA held", DATA, 16'h8008);
        chk("collide BUSY", BUSY, 1);
        chk("collide DONE", DONE, 0);
        wait_tick();
        cyc();
        chk("retarget DATA", DATA, 16'h8000);
        chk("retarget DONE", DONE, 1);
        chk("retarget BUSY", BUSY, 0);
        cyc();
        chk("retarget DONE single", DONE, 0);

        // HOLD freezes the ramp; step 0 jumps on release
        accept(16'h9000, 16'h0010);
        wait_tick();
        cyc();
        chk("pre-hold DATA", DATA, 16'h8010);
        HOLD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                SET_VALID = 1'b1;
                SET_CODE  = 16'h1234;
                SET_STEP  = 16'h0000;
            end
            cyc();
            SET_VALID = 1'b0;
            chk("hold DATA", DATA, 16'h8010);
        end
        HOLD = 1'b0;
        chk("hold BUSY", BUSY, 1);
        wait_tick();
        cyc();
        chk("step0 DATA", DATA, 16'h1234);
        chk("step0 DONE", DONE, 1);

        // Clamp / step / direction table
        for (int t = 0; t < 8; t++) begin
            prev  = DATA;
            nchg  = 0;
            ndone = 0;
            SET_VALID = 1'b1;
            SET_CODE  = tbl[t].code;
            SET_STEP  = tbl[t].step;
            for (int i = 0; i < 50; i++) begin
                cyc();
                SET_VALID = 1'b0;
                if (DATA != prev) nchg++;
                prev = DATA;
                if (DONE) ndone++;
            end
            chk($sformatf("tbl%0d DATA", t), DATA, tbl[t].exp_data);
            chk($sformatf("tbl%0d changes", t), nchg, tbl[t].exp_chg);
            chk($sformatf("tbl%0d DONE count", t), ndone, 1);
            chk($sformatf("tbl%0d BUSY", t), BUSY, 0);
        end

        // Reset mid-ramp, then equal-target accept
        accept(16'h9000, 16'h0001);
        wait_tick();
        cyc();
        chk("midramp BUSY", BUSY, 1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("midramp rst DATA", DATA, C_RST);
        chk("midramp rst BUSY", BUSY, 0);
        chk("midramp rst DONE", DONE, 0);
        chk("midramp rst READY", SET_READY, 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("post-rst DONE", DONE, 0);
        end
        accept(16'h8000, 16'h0005);
        chk("equal DONE", DONE, 1);
        chk("equal DATA", DATA, C_RST);
        chk("equal BUSY", BUSY, 0);
        cyc();
        chk("equal DONE single", DONE, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            RST       = ($urandom_range(0, 399) == 0);
            SET_VALID = ($urandom_range(0, 5) == 0);
            SET_CODE  = ($urandom_range(0, 7) == 0) ? m_data : 16'($urandom);
            case ($urandom_range(0, 3))
                0:       SET_STEP = 16'h0000;
                1:       SET_STEP = 16'($urandom_range(1, 16));
                2:       SET_STEP = 16'($urandom_range(16'h0100, 16'h2000));
                default: SET_STEP = 16'($urandom);
            endcase
            HOLD = ($urandom_range(0, 7) == 0);
            cyc();
        end
        RST       = 1'b0;
        SET_VALID = 1'b0;
        HOLD      = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
